fp_divsqrt_iter: RTL and testbench
==================================

# fp_divsqrt_iter

Iterative single-precision (IEEE-754 binary32) divide and square-root unit with parametrised radix, result tagging, abort and exception flags. Next-generation replacement for the divide path of the FP unit: the pipeline hands it an operation with `in_start`, holds issue while `out_stall` is high, and collects the result on `out_valid`. Add/sub/mul remain in the combinational FP datapath; this block owns the only multi-cycle FP operations.

## Interface
- `RADIX_LOG2`, default 1: quotient/root bits per iteration; legal values 1 or 2.
- `TAG_W`, default 5: width of the destination tag carried with the operation.
- `in_Clk`  in  1  clock, rising edge.
- `in_Rst_N`  in  1  reset, asynchronous, active-low.
- `in_start`  in  1  launch request; sampled only when idle.
- `in_op`  in  1  0 = divide `rs1/rs2`, 1 = square root of `rs1` (`rs2` ignored).
- `in_rs1`, `in_rs2`  in  32  operands.
- `in_tag`  in  TAG_W  tag captured at launch.
- `in_kill`  in  1  abort the in-flight operation (pipeline flush).
- `out_stall`  out  1  high while an operation is in flight.
- `out_valid`  out  1  one-cycle result pulse.
- `out_data`  out  32  result; holds its value until the next result.
- `out_tag`  out  TAG_W  tag of the result.
- `out_flags`  out  5  {NV, DZ, OF, UF, NX}, valid with `out_valid`.

## Operation
- States: IDLE, PREP, ITER, ROUND. `out_stall` = (state != IDLE).
- IDLE: `in_start`=1 captures operands, op and tag. Special case detected → result written directly, stay IDLE. Otherwise → PREP.
- PREP (1 cycle): unpack, exponent difference (div) or halved exponent with odd-exponent mantissa shift (sqrt), init remainder → ITER, counter = 0.
- ITER: N = 26/RADIX_LOG2 cycles (26 or 13), restoring digit recurrence yielding 24 mantissa + guard + round bits; sticky = (remainder != 0). Last iteration → ROUND.
- ROUND (1 cycle): normalise, round-to-nearest-even, range check → write outputs, → IDLE.
- Subnormal inputs are treated as signed zero; results below the normal range flush to signed zero with UF|NX. Exponent > 254 after rounding → signed infinity with OF|NX.
- Specials (1-cycle path): any NaN → 0x7fc00000 (NV only if an input is signalling); 0/0, inf/inf → 0x7fc00000 NV; x/0 (x finite non-zero) → signed inf, DZ; inf/x → signed inf; x/inf → signed zero; 0/x → signed zero; sqrt(negative non-zero) → 0x7fc00000 NV; sqrt(±0) → ±0; sqrt(+inf) → +inf.
- Sign of a divide result = XOR of operand signs, including zero and inf results.
- `in_kill`=1 in any non-IDLE state → IDLE next edge, no `out_valid`, `out_data`/`out_tag` unchanged. `in_kill` with `in_start` in IDLE: kill wins, nothing launched.

## Timing
- Reset: state IDLE, `out_stall`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `out_flags`=0, counter 0. Reset mid-operation discards it.
- Normal latency: launch at edge E0 → `out_valid` high in the cycle after edge E0+N+2 (28 edges at RADIX_LOG2=1, 15 at 2).
- Special-case latency: `out_valid` in the cycle after E0; `out_stall` never rises.
- `out_stall` rises the cycle after a normal launch and falls in the same cycle `out_valid` rises.
- `in_start` while `out_stall`=1 is ignored (no queueing). `in_start` in the `out_valid` cycle is accepted: back-to-back throughput is one result per N+2 cycles.

## Configuration
- `FP_DIVSQRT_SQRT_EN` defined: square root implemented as above.
- Not defined: sqrt hardware removed; `in_op`=1 returns 0x7fc00000 with NV on the 1-cycle special path, `out_stall` stays 0.

## Test plan
- Div 0x40c00000 / 0x40000000 (6.0/2.0) → 0x40400000, flags 0, `out_valid` exactly 28 edges (RADIX_LOG2=1) / 15 edges (=2) after launch, tag echoed.
- Rounding: 0xc0c00000 / 0x40400000 → 0xc0000000 exact, flags 0; 0x3f800000 / 0x40400000 → 0x3eaaaaab, NX only.
- Sqrt (macro defined): 0x40800000 → 0x40000000 flags 0; 0x40000000 → 0x3fb504f3 NX; 0xbf800000 → 0x7fc00000 NV; macro undefined: any sqrt → 0x7fc00000 NV in 1 cycle.
- Specials: 1.0/0.0 → 0x7f800000 DZ; 0/0 and inf/inf → 0x7fc00000 NV; 1.0/inf → 0x00000000; each `out_valid` 1 cycle after launch, `out_stall` stays 0.
- Range: 0x7f000000 / 0x3f000000 → 0x7f800000 OF|NX; 0x00800000 / 0x40000000 → 0x00000000 UF|NX.
- Control: `in_kill` at iteration 5 → no `out_valid`, stall drops next cycle, previous `out_data` kept; `in_start` during stall ignored; launch in `out_valid` cycle accepted; `in_Rst_N` low mid-ITER → all outputs 0 immediately.

Source files
------------

// File: rtl/fp_divsqrt_iter.sv
// fp_divsqrt_iter: iterative binary32 divide / square root; sqrt hardware enabled by FP_DIVSQRT_SQRT_EN
module fp_divsqrt_iter #(
    parameter int RADIX_LOG2 = 1,
    parameter int TAG_W      = 5
) (
    input  logic             in_Clk,
    input  logic             in_Rst_N,
    input  logic             in_start,
    input  logic             in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_kill,
    output logic             out_stall,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags
);
    localparam int N = 26 / RADIX_LOG2;
    localparam logic [31:0] QNAN = 32'h7fc00000;
`ifdef FP_DIVSQRT_SQRT_EN
    localparam bit SQRT_EN = 1'b1;
`else
    localparam bit SQRT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PREP, ITER, ROUND} state_t;
    state_t state, state_n;

    logic              a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan, sd;
    logic              sp_hit;
    logic [31:0]       sp_data;
    logic [4:0]        sp_flags;
    logic              op_q, sign_q;
    logic [TAG_W-1:0]  tag_q;
    logic [7:0]        ea_q, eb_q;
    logic [22:0]       fa_q, fb_q;
    logic [23:0]       d_q;
    logic signed [9:0] exp_q, ef;
    logic [27:0]       rem_q, r_n;
    logic [25:0]       q_q, q_n, rad_q, rad_n;
    logic [4:0]        cnt;
    logic              ge, top, g, s, inc, carry, of, uf;
    logic [22:0]       frac, frac_r;

    assign a_zero = in_rs1[30:23] == 8'h00;
    assign a_inf  = in_rs1[30:23] == 8'hff && in_rs1[22:0] == 23'd0;
    assign a_nan  = in_rs1[30:23] == 8'hff && in_rs1[22:0] != 23'd0;
    assign a_snan = a_nan && !in_rs1[22];
    assign b_zero = in_rs2[30:23] == 8'h00;
    assign b_inf  = in_rs2[30:23] == 8'hff && in_rs2[22:0] == 23'd0;
    assign b_nan  = in_rs2[30:23] == 8'hff && in_rs2[22:0] != 23'd0;
    assign b_snan = b_nan && !in_rs2[22];
    assign sd     = in_rs1[31] ^ in_rs2[31];

    // special-operand decode feeding the single-cycle result path
    always_comb begin
        sp_hit   = 1'b1;
        sp_data  = QNAN;
        sp_flags = 5'b00000;
        if (in_op) begin
            if (!SQRT_EN) sp_flags = 5'b10000;
            else if (a_nan) sp_flags = {a_snan, 4'b0000};
            else if (a_zero) sp_data = {in_rs1[31], 31'd0};
            else if (in_rs1[31]) sp_flags = 5'b10000;
            else if (a_inf) sp_data = 32'h7f800000;
            else sp_hit = 1'b0;
        end else begin
            if (a_nan || b_nan) sp_flags = {a_snan | b_snan, 4'b0000};
            else if ((a_zero && b_zero) || (a_inf && b_inf)) sp_flags = 5'b10000;
            else if (a_inf) sp_data = {sd, 31'h7f800000};
            else if (b_zero) begin
                sp_data  = {sd, 31'h7f800000};
                sp_flags = 5'b01000;
            end
            else if (a_zero || b_inf) sp_data = {sd, 31'd0};
            else sp_hit = 1'b0;
        end
    end

    // state register
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) state <= IDLE;
        else state <= state_n;
    end

    // next state: kill always wins and returns to IDLE
    always_comb begin
        state_n = state;
        if (in_kill) state_n = IDLE;
        else begin
            case (state)
                IDLE:    state_n = (in_start && !sp_hit) ? PREP : IDLE;
                PREP:    state_n = ITER;
                ITER:    state_n = (cnt == 5'(N - 1)) ? ROUND : ITER;
                default: state_n = IDLE;
            endcase
        end
    end

    assign out_stall = state != IDLE;

    // RADIX_LOG2 restoring steps per cycle: divide shifts the remainder, sqrt pulls two radicand bits
    always_comb begin
        r_n   = rem_q;
        q_n   = q_q;
        rad_n = rad_q;
        ge    = 1'b0;
        for (int k = 0; k < RADIX_LOG2; k++) begin
            if (op_q) begin
                r_n   = {r_n[25:0], rad_n[25:24]};
                rad_n = {rad_n[23:0], 2'b00};
                ge    = r_n >= {q_n, 2'b01};
                if (ge) r_n = r_n - {q_n, 2'b01};
            end else begin
                ge = r_n >= {4'd0, d_q};
                if (ge) r_n = r_n - {4'd0, d_q};
                r_n = {r_n[26:0], 1'b0};
            end
            q_n = {q_n[24:0], ge};
        end
    end

    // operand capture, unpack/initialisation and iteration registers
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            op_q   <= 1'b0;
            sign_q <= 1'b0;
            tag_q  <= '0;
            ea_q   <= 8'd0;
            eb_q   <= 8'd0;
            fa_q   <= 23'd0;
            fb_q   <= 23'd0;
            d_q    <= 24'd0;
            exp_q  <= 10'sd0;
            rem_q  <= 28'd0;
            q_q    <= 26'd0;
            rad_q  <= 26'd0;
            cnt    <= 5'd0;
        end else if (state == IDLE) begin
            if (in_start) begin
                op_q   <= in_op & SQRT_EN;
                sign_q <= in_op ? 1'b0 : sd;
                tag_q  <= in_tag;
                ea_q   <= in_rs1[30:23];
                eb_q   <= in_rs2[30:23];
                fa_q   <= in_rs1[22:0];
                fb_q   <= in_rs2[22:0];
            end
        end else if (state == PREP) begin
            cnt   <= 5'd0;
            d_q   <= {1'b1, fb_q};
            q_q   <= 26'd0;
            rem_q <= op_q ? 28'd0 : {4'd0, 1'b1, fa_q};
            rad_q <= ea_q[0] ? {2'b01, fa_q, 1'b0} : {1'b1, fa_q, 2'b00};
            exp_q <= op_q ? $signed({3'd0, ea_q[7:1]} + 10'd63 + {9'd0, ea_q[0]})
                          : $signed({2'd0, ea_q}) - $signed({2'd0, eb_q}) + 10'sd127;
        end else if (state == ITER) begin
            rem_q <= r_n;
            q_q   <= q_n;
            rad_q <= rad_n;
            cnt   <= cnt + 5'd1;
        end
    end

    assign top    = q_q[25];
    assign frac   = top ? q_q[24:2] : q_q[23:1];
    assign g      = top ? q_q[1] : q_q[0];
    assign s      = (top & q_q[0]) | (rem_q != 28'd0);
    assign inc    = g & (s | frac[0]);
    assign carry  = inc & (&frac);
    assign frac_r = frac + {22'd0, inc};
    assign ef     = exp_q - $signed({9'd0, !top}) + $signed({9'd0, carry});
    assign of     = ef > 10'sd254;
    assign uf     = ef < 10'sd1;

    // result registers: special path from IDLE, rounded result from ROUND
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_tag   <= '0;
            out_flags <= 5'd0;
        end else begin
            out_valid <= 1'b0;
            if (!in_kill && state == IDLE && in_start && sp_hit) begin
                out_valid <= 1'b1;
                out_data  <= sp_data;
                out_flags <= sp_flags;
                out_tag   <= in_tag;
            end else if (!in_kill && state == ROUND) begin
                out_valid <= 1'b1;
                out_data  <= of ? {sign_q, 8'hff, 23'd0} : uf ? {sign_q, 31'd0} : {sign_q, ef[7:0], frac_r};
                out_flags <= {2'b00, of, uf, of | uf | g | s};
                out_tag   <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_fp_divsqrt_iter.sv
// tb_fp_divsqrt_iter: directed self-checking bench for fp_divsqrt_iter
module tb_fp_divsqrt_iter;
    localparam int RADIX = 1;
    localparam int LAT   = 26 / RADIX + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start = 1'b0, in_op = 1'b0, in_kill = 1'b0;
    logic [31:0] in_rs1 = 32'd0, in_rs2 = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_stall, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_tag, out_flags;
    int checks = 0;
    int errors = 0;

    fp_divsqrt_iter #(.RADIX_LOG2(RADIX), .TAG_W(5)) dut (
        .in_Clk(clk), .in_Rst_N(rst_n), .in_start(in_start), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .in_kill(in_kill),
        .out_stall(out_stall), .out_valid(out_valid), .out_data(out_data),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        in_start = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output logic stall_seen);
        lat = -1;
        stall_seen = 1'b0;
        for (int k = 0; k <= LAT + 5; k++) begin
            if (out_stall) stall_seen = 1'b1;
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          output int lat, output logic stall_seen);
        @(negedge clk);
        launch(op, a, b, tag);
        wait_valid(lat, stall_seen);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", out_stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if ({out_tag, out_flags} !== 10'd0) begin errors++; $display("FAIL reset_tag_flags got %h want 0", {out_tag, out_flags}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_release_stall got %b want 0", out_stall); end
    endtask

    task automatic test_div;
        int lat; logic st;
        run_op(1'b0, 32'h40c00000, 32'h40000000, 5'h13, lat, st);
        checks++; if (lat != LAT) begin errors++; $display("FAIL div_latency got %0d want %0d", lat, LAT); end
        checks++; if (out_data !== 32'h40400000) begin errors++; $display("FAIL div_6_2 got %h want 40400000", out_data); end
        checks++; if (out_flags !== 5'b00000) begin errors++; $display("FAIL div_6_2_flags got %b want 00000", out_flags); end
        checks++; if (out_tag !== 5'h13) begin errors++; $display("FAIL div_tag got %h want 13", out_tag); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div_valid_pulse got %b want 0", out_valid); end
        run_op(1'b0, 32'hc0c00000, 32'h40400000, 5'h02, lat, st);
        checks++; if (out_data !== 32'hc0000000) begin errors++; $display("FAIL div_neg6_3 got %h want c0000000", out_data); end
        checks++; if (out_flags !== 5'b00000) begin errors++; $display("FAIL div_neg6_3_flags got %b want 00000", out_flags); end
        run_op(1'b0, 32'h3f800000, 32'h40400000, 5'h04, lat, st);
        checks++; if (out_data !== 32'h3eaaaaab) begin errors++; $display("FAIL div_1_3 got %h want 3eaaaaab", out_data); end
        checks++; if (out_flags !== 5'b00001) begin errors++; $display("FAIL div_1_3_flags got %b want 00001", out_flags); end
    endtask

    task automatic test_sqrt;
        int lat; logic st;
`ifdef FP_DIVSQRT_SQRT_EN
        run_op(1'b1, 32'h40800000, 32'hdeadbeef, 5'h05, lat, st);
        checks++; if (lat != LAT) begin errors++; $display("FAIL sqrt_latency got %0d want %0d", lat, LAT); end
        checks++; if ({out_data, out_flags} !== {32'h40000000, 5'b00000}) begin errors++; $display("FAIL sqrt_4 got %h/%b want 40000000/00000", out_data, out_flags); end
        run_op(1'b1, 32'h40000000, 32'd0, 5'h06, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h3fb504f3, 5'b00001}) begin errors++; $display("FAIL sqrt_2 got %h/%b want 3fb504f3/00001", out_data, out_flags); end
        run_op(1'b1, 32'hbf800000, 32'd0, 5'h07, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7fc00000, 5'b10000}) begin errors++; $display("FAIL sqrt_neg got %h/%b want 7fc00000/10000", out_data, out_flags); end
        checks++; if (lat != 0 || st !== 1'b0) begin errors++; $display("FAIL sqrt_neg_path got lat %0d stall %b want 0 0", lat, st); end
`else
        run_op(1'b1, 32'h40800000, 32'd0, 5'h05, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7fc00000, 5'b10000}) begin errors++; $display("FAIL sqrt_off got %h/%b want 7fc00000/10000", out_data, out_flags); end
        checks++; if (lat != 0 || st !== 1'b0) begin errors++; $display("FAIL sqrt_off_path got lat %0d stall %b want 0 0", lat, st); end
        checks++; if (out_tag !== 5'h05) begin errors++; $display("FAIL sqrt_off_tag got %h want 05", out_tag); end
`endif
    endtask

    task automatic test_special;
        int lat; logic st;
        run_op(1'b0, 32'h3f800000, 32'h00000000, 5'h08, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7f800000, 5'b01000}) begin errors++; $display("FAIL sp_1_0 got %h/%b want 7f800000/01000", out_data, out_flags); end
        checks++; if (lat != 0 || st !== 1'b0) begin errors++; $display("FAIL sp_path got lat %0d stall %b want 0 0", lat, st); end
        checks++; if (out_tag !== 5'h08) begin errors++; $display("FAIL sp_tag got %h want 08", out_tag); end
        run_op(1'b0, 32'hbf800000, 32'h00000000, 5'h09, lat, st);
        checks++; if ({out_data, out_flags} !== {32'hff800000, 5'b01000}) begin errors++; $display("FAIL sp_neg1_0 got %h/%b want ff800000/01000", out_data, out_flags); end
        run_op(1'b0, 32'h00000000, 32'h80000000, 5'h0a, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7fc00000, 5'b10000}) begin errors++; $display("FAIL sp_0_0 got %h/%b want 7fc00000/10000", out_data, out_flags); end
        run_op(1'b0, 32'h7f800000, 32'hff800000, 5'h0b, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7fc00000, 5'b10000}) begin errors++; $display("FAIL sp_inf_inf got %h/%b want 7fc00000/10000", out_data, out_flags); end
        run_op(1'b0, 32'h3f800000, 32'h7f800000, 5'h0c, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h00000000, 5'b00000}) begin errors++; $display("FAIL sp_1_inf got %h/%b want 00000000/00000", out_data, out_flags); end
        checks++; if (lat != 0 || st !== 1'b0) begin errors++; $display("FAIL sp_1_inf_path got lat %0d stall %b want 0 0", lat, st); end
        run_op(1'b0, 32'h7fc00000, 32'h3f800000, 5'h0d, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7fc00000, 5'b00000}) begin errors++; $display("FAIL sp_qnan got %h/%b want 7fc00000/00000", out_data, out_flags); end
        run_op(1'b0, 32'h3f800000, 32'h7f800001, 5'h0e, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7fc00000, 5'b10000}) begin errors++; $display("FAIL sp_snan got %h/%b want 7fc00000/10000", out_data, out_flags); end
    endtask

    task automatic test_range;
        int lat; logic st;
        run_op(1'b0, 32'h7f000000, 32'h3f000000, 5'h10, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h7f800000, 5'b00101}) begin errors++; $display("FAIL range_of got %h/%b want 7f800000/00101", out_data, out_flags); end
        run_op(1'b0, 32'h00800000, 32'h40000000, 5'h11, lat, st);
        checks++; if ({out_data, out_flags} !== {32'h00000000, 5'b00011}) begin errors++; $display("FAIL range_uf got %h/%b want 00000000/00011", out_data, out_flags); end
    endtask

    task automatic test_kill;
        logic [31:0] prev_data; logic [4:0] prev_tag; int seen;
        prev_data = out_data;
        prev_tag  = out_tag;
        @(negedge clk);
        launch(1'b0, 32'h40c00000, 32'h40000000, 5'h1f);
        repeat (6) @(negedge clk);
        in_kill = 1'b1;
        @(negedge clk);
        in_kill = 1'b0;
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL kill_stall got %b want 0", out_stall); end
        seen = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL kill_no_valid got %0d pulses want 0", seen); end
        checks++; if ({out_data, out_tag} !== {prev_data, prev_tag}) begin errors++; $display("FAIL kill_hold got %h/%h want %h/%h", out_data, out_tag, prev_data, prev_tag); end
        in_kill = 1'b1;
        launch(1'b0, 32'h40c00000, 32'h40000000, 5'h1e);
        in_kill = 1'b0;
        checks++; if (out_stall !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL kill_idle_start got stall %b valid %b want 0 0", out_stall, out_valid); end
    endtask

    task automatic test_ignore_start;
        int lat; logic st; int seen;
        @(negedge clk);
        launch(1'b0, 32'h3f800000, 32'h40400000, 5'h03);
        repeat (3) @(negedge clk);
        launch(1'b0, 32'h40c00000, 32'h40000000, 5'h09);
        wait_valid(lat, st);
        checks++; if (lat + 4 != LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat + 4, LAT); end
        checks++; if ({out_data, out_tag} !== {32'h3eaaaaab, 5'h03}) begin errors++; $display("FAIL ignore_result got %h/%h want 3eaaaaab/03", out_data, out_tag); end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_stall || out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL ignore_no_queue got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat; logic st;
        run_op(1'b0, 32'h40c00000, 32'h40000000, 5'h01, lat, st);
        checks++; if ({out_data, out_tag} !== {32'h40400000, 5'h01}) begin errors++; $display("FAIL b2b_first got %h/%h want 40400000/01", out_data, out_tag); end
        launch(1'b0, 32'h3f800000, 32'h40400000, 5'h02);
        wait_valid(lat, st);
        checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        checks++; if ({out_data, out_flags, out_tag} !== {32'h3eaaaaab, 5'b00001, 5'h02}) begin errors++; $display("FAIL b2b_second got %h/%b/%h want 3eaaaaab/00001/02", out_data, out_flags, out_tag); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        launch(1'b0, 32'h40c00000, 32'h40000000, 5'h15);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({out_stall, out_valid, out_data, out_tag, out_flags} !== 44'd0) begin errors++; $display("FAIL reset_mid got %h want 0", {out_stall, out_valid, out_data, out_tag, out_flags}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(negedge clk);
        checks++; if ({out_stall, out_valid, out_data} !== 34'd0) begin errors++; $display("FAIL reset_mid_discard got %h want 0", {out_stall, out_valid, out_data}); end
    endtask

    initial begin
        test_reset;
        test_div;
        test_sqrt;
        test_special;
        test_range;
        test_kill;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
